// File: rtl/adder_pkg.sv
// Shared definitions for the multi-word adder built around the 32-bit carry-skip core.
package adder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-word configuration still needs a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/carry_skip_adder_32bit.sv
// Combinational 32-bit carry-skip adder: 4-bit ripple blocks whose carry bypasses
// a block whenever every bit of that block propagates.
module carry_skip_adder_32bit
  import adder_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int BLK_W = 4;
  localparam int N_BLK = WORD_W / BLK_W;

  always_comb begin
    logic c;
    logic rc;
    logic blk_p;
    c     = cin;
    rc    = 1'b0;
    blk_p = 1'b0;
    sum   = '0;
    for (int b = 0; b < N_BLK; b++) begin
      rc    = c;
      blk_p = 1'b1;
      for (int i = 0; i < BLK_W; i++) begin
        sum[b*BLK_W+i] = A[b*BLK_W+i] ^ B[b*BLK_W+i] ^ rc;
        rc    = (A[b*BLK_W+i] & B[b*BLK_W+i]) | (rc & (A[b*BLK_W+i] ^ B[b*BLK_W+i]));
        blk_p = blk_p & (A[b*BLK_W+i] ^ B[b*BLK_W+i]);
      end
      c = blk_p ? c : rc;
    end
    cout = c;
  end

endmodule

// File: rtl/multiword_carry_skip_adder.sv
// Sequential WORDS*32-bit adder: one word slice per clock through a single
// carry-skip core, least significant word first, carry held in a flop between slices.
//
// state | meaning
// IDLE  | waiting for an operand bundle; in_ready high
// RUN   | adding word idx; carry flop feeds the core
// DONE  | result valid; held until out_ready
module multiword_carry_skip_adder
  import adder_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] in_a,
  input  logic [WORDS*WORD_W-1:0] in_b,
  input  logic                    in_cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] out_sum,
  output logic                    out_cout,
  output logic                    busy
);

  localparam int IDX_W = idx_width(WORDS);
  localparam int TOT_W = WORDS * WORD_W;

  state_e             state;
  state_e             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [TOT_W-1:0]   op_a;
  logic [TOT_W-1:0]   op_b;
  logic [WORD_W-1:0]  slice_a;
  logic [WORD_W-1:0]  slice_b;
  logic [WORD_W-1:0]  slice_sum;
  logic               slice_cout;
  logic               last_word;
  logic               accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = !in_ready;
  assign accept    = in_valid && in_ready;
  assign last_word = (idx == IDX_W'(WORDS - 1));
  assign slice_a   = op_a[idx*WORD_W +: WORD_W];
  assign slice_b   = op_b[idx*WORD_W +: WORD_W];

  carry_skip_adder_32bit u_core (
    .A    (slice_a),
    .B    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_word) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (accept) begin
      op_a  <= in_a;
      op_b  <= in_b;
      carry <= in_cin;
      idx   <= '0;
    end else if (state == RUN) begin
      out_sum[idx*WORD_W +: WORD_W] <= slice_sum;
      carry <= slice_cout;
      idx   <= idx + IDX_W'(1);
      // Result words above idx still hold the previous op until overwritten here.
      if (last_word) out_cout <= slice_cout;
    end
  end

endmodule
